// File: rtl/ifu_irf_errinj_log_ctl_if.sv
// Signal bundle between the IFU IRF error log / injection control and its EXU/CSR neighbours.
interface ifu_irf_errinj_log_ctl_if #(
    parameter int unsigned CE_CNT_W = 4
);
    logic                exu_ifu_ecc_ce_m;
    logic                exu_ifu_ecc_ue_m;
    logic [7:0]          exu_ifu_err_reg_m;
    logic                exu_ifu_err_synd_7_m;
    logic                exu_ifu_inj_ack;
    logic                inst_vld_m;
    logic                csr_inj_wr;
    logic [7:0]          csr_inj_mask;
    logic                csr_inj_oneshot;
    logic                csr_inj_cancel;
    logic                csr_log_clr;
    logic [CE_CNT_W-1:0] csr_ce_thresh;
    logic                ifu_exu_inj_irferr;
    logic [7:0]          ifu_exu_ecc_mask;
    logic                ifu_exu_disable_ce_e;
    logic                log_vld;
    logic                log_ue;
    logic                log_meu;
    logic [7:0]          log_reg;
    logic                log_synd7;
    logic                ce_replay_w;
    logic                ue_intr_req;
    logic                inj_busy;
    logic                inj_tmo;

    modport master (
        output exu_ifu_ecc_ce_m, exu_ifu_ecc_ue_m, exu_ifu_err_reg_m, exu_ifu_err_synd_7_m,
               exu_ifu_inj_ack, inst_vld_m, csr_inj_wr, csr_inj_mask, csr_inj_oneshot,
               csr_inj_cancel, csr_log_clr, csr_ce_thresh,
        input  ifu_exu_inj_irferr, ifu_exu_ecc_mask, ifu_exu_disable_ce_e, log_vld, log_ue,
               log_meu, log_reg, log_synd7, ce_replay_w, ue_intr_req, inj_busy, inj_tmo
    );

    modport slave (
        input  exu_ifu_ecc_ce_m, exu_ifu_ecc_ue_m, exu_ifu_err_reg_m, exu_ifu_err_synd_7_m,
               exu_ifu_inj_ack, inst_vld_m, csr_inj_wr, csr_inj_mask, csr_inj_oneshot,
               csr_inj_cancel, csr_log_clr, csr_ce_thresh,
        output ifu_exu_inj_irferr, ifu_exu_ecc_mask, ifu_exu_disable_ce_e, log_vld, log_ue,
               log_meu, log_reg, log_synd7, ce_replay_w, ue_intr_req, inj_busy, inj_tmo
    );
endinterface

// File: rtl/ifu_irf_errinj_log_ctl.sv
// IFU IRF ECC control: one-deep CE/UE log, saturating CE counter with disable_ce threshold,
// and the error-injection FSM that arms EXU check-bit flips.
module ifu_irf_errinj_log_ctl #(
    parameter int unsigned CE_CNT_W  = 4,
    parameter int unsigned INJ_TMO_W = 6
) (
    input  logic                        clk,
    input  logic                        arst_l,
    ifu_irf_errinj_log_ctl_if.slave     bus_io
);
    typedef enum logic [1:0] {StIdle, StArmed, StDrain} inj_state_e;

    logic                 ce_qual, ue_qual, report;
    logic                 log_vld_q, log_ue_q, log_meu_q, log_synd7_q, ce_replay_q;
    logic [7:0]           log_reg_q;
    logic [CE_CNT_W-1:0]  ce_cnt_q;
    logic                 disable_ce_q;
    inj_state_e           state_q;
    logic [7:0]           mask_q, ecc_mask_q;
    logic                 oneshot_q, irferr_q, inj_tmo_q;
    logic [INJ_TMO_W-1:0] tmo_cnt_q, tmo_inc;

    // UE wins over a simultaneous CE; flushed instructions report nothing.
    assign ce_qual = bus_io.exu_ifu_ecc_ce_m & ~bus_io.exu_ifu_ecc_ue_m & bus_io.inst_vld_m;
    assign ue_qual = bus_io.exu_ifu_ecc_ue_m & bus_io.inst_vld_m;
    assign report  = ce_qual | ue_qual;
    assign tmo_inc = tmo_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            log_vld_q   <= 1'b0;
            log_ue_q    <= 1'b0;
            log_meu_q   <= 1'b0;
            log_reg_q   <= 8'h00;
            log_synd7_q <= 1'b0;
            ce_replay_q <= 1'b0;
        end else begin
            ce_replay_q <= ce_qual;
            if (bus_io.csr_log_clr) begin
                // A report coincident with the clear lands in a fresh log.
                log_vld_q   <= report;
                log_ue_q    <= ue_qual;
                log_meu_q   <= 1'b0;
                log_reg_q   <= report ? bus_io.exu_ifu_err_reg_m : 8'h00;
                log_synd7_q <= report & bus_io.exu_ifu_err_synd_7_m;
            end else if (report) begin
                if (!log_vld_q) begin
                    log_vld_q   <= 1'b1;
                    log_ue_q    <= ue_qual;
                    log_reg_q   <= bus_io.exu_ifu_err_reg_m;
                    log_synd7_q <= bus_io.exu_ifu_err_synd_7_m;
                end else begin
                    log_meu_q <= 1'b1;
                    if (!log_ue_q && ue_qual) begin
                        log_ue_q    <= 1'b1;
                        log_reg_q   <= bus_io.exu_ifu_err_reg_m;
                        log_synd7_q <= bus_io.exu_ifu_err_synd_7_m;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ce_cnt_q     <= '0;
            disable_ce_q <= 1'b0;
        end else begin
            if (bus_io.csr_log_clr) begin
                ce_cnt_q <= '0;
            end else if (ce_qual && (ce_cnt_q != '1)) begin
                ce_cnt_q <= ce_cnt_q + 1'b1;
            end
            disable_ce_q <= (bus_io.csr_ce_thresh != '0) && (ce_cnt_q >= bus_io.csr_ce_thresh);
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= StIdle;
            mask_q     <= 8'h00;
            ecc_mask_q <= 8'h00;
            oneshot_q  <= 1'b0;
            irferr_q   <= 1'b0;
            inj_tmo_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            if (bus_io.csr_inj_wr) begin
                inj_tmo_q <= 1'b0;
            end
            unique case (state_q)
                StArmed: begin
                    if (bus_io.csr_inj_cancel) begin
                        state_q    <= StIdle;
                        irferr_q   <= 1'b0;
                        ecc_mask_q <= 8'h00;
                    end else if (bus_io.csr_inj_wr) begin
                        mask_q     <= bus_io.csr_inj_mask;
                        ecc_mask_q <= bus_io.csr_inj_mask;
                        oneshot_q  <= bus_io.csr_inj_oneshot;
                        tmo_cnt_q  <= '0;
                    end else if (bus_io.exu_ifu_inj_ack) begin
                        tmo_cnt_q <= '0;
                        if (oneshot_q) begin
                            state_q    <= StDrain;
                            irferr_q   <= 1'b0;
                            ecc_mask_q <= 8'h00;
                        end
                    end else if (&tmo_inc) begin
                        state_q    <= StIdle;
                        irferr_q   <= 1'b0;
                        ecc_mask_q <= 8'h00;
                        inj_tmo_q  <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_inc;
                    end
                end
                StIdle, StDrain: begin
                    // Late acks are ignored here; a new arm request is honoured right away.
                    if (bus_io.csr_inj_wr && !bus_io.csr_inj_cancel) begin
                        state_q    <= StArmed;
                        mask_q     <= bus_io.csr_inj_mask;
                        ecc_mask_q <= bus_io.csr_inj_mask;
                        oneshot_q  <= bus_io.csr_inj_oneshot;
                        irferr_q   <= 1'b1;
                        tmo_cnt_q  <= '0;
                    end else begin
                        state_q    <= StIdle;
                        irferr_q   <= 1'b0;
                        ecc_mask_q <= 8'h00;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    irferr_q   <= 1'b0;
                    ecc_mask_q <= 8'h00;
                end
            endcase
        end
    end

    assign bus_io.ifu_exu_inj_irferr   = irferr_q;
    assign bus_io.ifu_exu_ecc_mask     = ecc_mask_q;
    assign bus_io.ifu_exu_disable_ce_e = disable_ce_q;
    assign bus_io.log_vld              = log_vld_q;
    assign bus_io.log_ue               = log_ue_q;
    assign bus_io.log_meu              = log_meu_q;
    assign bus_io.log_reg              = log_reg_q;
    assign bus_io.log_synd7            = log_synd7_q;
    assign bus_io.ce_replay_w          = ce_replay_q;
    assign bus_io.ue_intr_req          = log_vld_q & log_ue_q;
    assign bus_io.inj_busy             = (state_q != StIdle);
    assign bus_io.inj_tmo              = inj_tmo_q;
endmodule
